// File: rtl/fifo_wr_framer_if.sv
// rtl/fifo_wr_framer_if.sv - producer byte stream and FIFO write port bundle
interface fifo_wr_framer_if;
  logic       i_valid;
  logic [7:0] i_data;
  logic       i_last;
  logic       o_ready;
  logic       i_full;
  logic       o_wren;
  logic [7:0] o_wdata;

  modport slave  (input  i_valid, i_data, i_last, i_full,
                  output o_ready, o_wren, o_wdata);
  modport master (output i_valid, i_data, i_last, i_full,
                  input  o_ready, o_wren, o_wdata);
endinterface

// File: rtl/fifo_wr_framer.sv
// rtl/fifo_wr_framer.sv - HDLC-style write-side framer: flag, stuffed payload, stuffed checksum, flag
module fifo_wr_framer #(
  parameter logic [7:0] FLAG  = 8'h7E,
  parameter logic [7:0] ESC   = 8'h7D,
  parameter logic [7:0] XMASK = 8'h20
) (
  input  logic              i_wrclk,
  input  logic              i_wrst_n,
  fifo_wr_framer_if.slave   bus,
  output logic              o_busy,
  output logic [15:0]       o_frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_DATA, S_DATA_X, S_CHK, S_CHK_X, S_EOF
  } state_t;

  state_t      r_state;
  logic [7:0]  r_sum;
  logic [15:0] r_frame_cnt;
  logic        r_busy;

  logic        w_in_special;
  logic        w_chk_special;
  logic [7:0]  w_chk;
  logic        w_wren;
  logic        w_ready;
  logic [7:0]  w_wdata;

  assign w_chk         = ~r_sum;
  assign w_in_special  = (bus.i_data == FLAG) || (bus.i_data == ESC);
  assign w_chk_special = (w_chk == FLAG) || (w_chk == ESC);

  // Every write is gated by !i_full, so the FIFO never has to drop a byte.
  always_comb begin
    w_wren  = 1'b0;
    w_ready = 1'b0;
    w_wdata = 8'h00;
    case (r_state)
      S_SOF: begin
        w_wren  = !bus.i_full;
        w_wdata = FLAG;
      end
      S_DATA: begin
        w_wren  = bus.i_valid && !bus.i_full;
        w_wdata = w_in_special ? ESC : bus.i_data;
        w_ready = w_wren && !w_in_special;
      end
      S_DATA_X: begin
        w_wren  = !bus.i_full;
        w_wdata = bus.i_data ^ XMASK;
        w_ready = w_wren;
      end
      S_CHK: begin
        w_wren  = !bus.i_full;
        w_wdata = w_chk_special ? ESC : w_chk;
      end
      S_CHK_X: begin
        w_wren  = !bus.i_full;
        w_wdata = w_chk ^ XMASK;
      end
      S_EOF: begin
        w_wren  = !bus.i_full;
        w_wdata = FLAG;
      end
      default: begin
        w_wren  = 1'b0;
        w_ready = 1'b0;
        w_wdata = 8'h00;
      end
    endcase
  end

  assign bus.o_wren  = w_wren;
  assign bus.o_ready = w_ready;
  assign bus.o_wdata = w_wdata;
  assign o_busy      = r_busy;
  assign o_frame_cnt = r_frame_cnt;

  always_ff @(posedge i_wrclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      r_state     <= S_IDLE;
      r_sum       <= 8'h00;
      r_frame_cnt <= 16'h0000;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_valid) begin
            r_state <= S_SOF;
            r_sum   <= 8'h00;
            r_busy  <= 1'b1;
          end
        end
        S_SOF: begin
          if (w_wren) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_wren) begin
            if (w_in_special) begin
              r_state <= S_DATA_X;
            end else begin
              r_sum   <= r_sum + bus.i_data;
              r_state <= bus.i_last ? S_CHK : S_DATA;
            end
          end
        end
        S_DATA_X: begin
          if (w_wren) begin
            r_sum   <= r_sum + bus.i_data;
            r_state <= bus.i_last ? S_CHK : S_DATA;
          end
        end
        S_CHK: begin
          if (w_wren) r_state <= w_chk_special ? S_CHK_X : S_EOF;
        end
        S_CHK_X: begin
          if (w_wren) r_state <= S_EOF;
        end
        S_EOF: begin
          if (w_wren) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_framer.sv
// tb/tb_fifo_wr_framer.sv - self-checking bench for fifo_wr_framer with a byte-stream reference model
module tb_fifo_wr_framer;

  localparam logic [7:0] FLAG  = 8'h7E;
  localparam logic [7:0] ESC   = 8'h7D;
  localparam logic [7:0] XMASK = 8'h20;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] frame_cnt;

  fifo_wr_framer_if bus();

  fifo_wr_framer #(.FLAG(FLAG), .ESC(ESC), .XMASK(XMASK)) dut (
    .i_wrclk     (clk),
    .i_wrst_n    (rst_n),
    .bus         (bus),
    .o_busy      (busy),
    .o_frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  cap_q[$];
  logic [7:0]  acc_q[$];
  logic [7:0]  rdy_q[$];
  logic        full_sched[$];
  bit          rand_full;
  bit          rand_gap;
  int          abort_after;
  int          frame_cycles;
  int          gate_viol;
  int          gate_seen;
  logic [15:0] exp_cnt;
  int          n_checks;
  int          n_fail;

  function automatic void push_stuffed(input logic [7:0] b);
    if (b == FLAG || b == ESC) begin
      exp_q.push_back(ESC);
      exp_q.push_back(b ^ XMASK);
    end else begin
      exp_q.push_back(b);
    end
  endfunction

  // Frame = FLAG, stuffed payload, stuffed ~(sum mod 256), FLAG.
  function automatic void build_exp();
    logic [7:0] s;
    s = 8'h00;
    exp_q.delete();
    exp_q.push_back(FLAG);
    foreach (tx_q[i]) begin
      s = s + tx_q[i];
      push_stuffed(tx_q[i]);
    end
    push_stuffed(~s);
    exp_q.push_back(FLAG);
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) return i;
    if (cap_q.size() != exp_q.size()) return exp_q.size();
    return -1;
  endfunction

  function automatic bit acc_ok();
    if (acc_q.size() != tx_q.size()) return 1'b0;
    foreach (tx_q[i]) if (acc_q[i] !== tx_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Producer + FIFO stand-in: drives one frame, records every FIFO write and accepted byte.
  task automatic run_frame();
    int idx;
    int cyc;
    int gap;
    bit done;
    idx = 0; cyc = 0; gap = 0; done = 1'b0;
    cap_q.delete(); acc_q.delete(); rdy_q.delete();
    frame_cycles = -1; gate_viol = 0; gate_seen = 0;
    while (!done) begin
      @(posedge clk); #1;
      if (cyc < full_sched.size()) bus.i_full = full_sched[cyc];
      else bus.i_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (idx < tx_q.size() && gap == 0) begin
        bus.i_valid = 1'b1;
        bus.i_data  = tx_q[idx];
        bus.i_last  = (idx == tx_q.size() - 1);
      end else begin
        bus.i_valid = 1'b0;
        bus.i_data  = 8'($urandom);
        bus.i_last  = 1'($urandom);
        if (gap > 0) gap--;
      end
      @(negedge clk);
      cyc++;
      if (bus.o_wren) cap_q.push_back(bus.o_wdata);
      if (bus.i_full) begin
        gate_seen++;
        if (bus.o_wren !== 1'b0 || bus.o_ready !== 1'b0) gate_viol++;
      end
      if (bus.i_valid && bus.o_ready) begin
        acc_q.push_back(bus.i_data);
        rdy_q.push_back(bus.o_wdata);
        idx++;
        if (rand_gap) gap = $urandom_range(0, 2);
      end
      if (idx == tx_q.size() && !busy) begin
        done = 1'b1;
        frame_cycles = cyc - 1;
      end
      if (abort_after > 0 && cap_q.size() >= abort_after) done = 1'b1;
      if (cyc >= 2000) done = 1'b1;
    end
    bus.i_valid = 1'b0;
    bus.i_full  = 1'b0;
  endtask

  task automatic test_reset();
    int d;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.i_valid = 1'($urandom); bus.i_data = 8'($urandom);
      bus.i_last = 1'($urandom); bus.i_full = 1'($urandom);
    end
    @(negedge clk);
    n_checks++; if (bus.o_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b want 0", bus.o_wren); end
    n_checks++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", bus.o_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_frame_cnt got %h want 0000", frame_cnt); end
    n_checks++; if (bus.o_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata got %h want 00", bus.o_wdata); end
    bus.i_valid = 1'b0; bus.i_full = 1'b0;
    rst_n = 1'b1;
    exp_cnt = 16'h0000;
    d = 0;
  endtask

  task automatic test_plain();
    int d;
    tx_q = '{8'h01, 8'h02};
    run_frame();
    exp_q = '{8'h7E, 8'h01, 8'h02, 8'hFC, 8'h7E};
    exp_cnt++;
    d = first_diff();
    n_checks++; if (d != -1) begin n_fail++; $display("FAIL plain_bytes idx %0d got %h want %h", d, cap_q[d], exp_q[d]); end
    n_checks++; if (frame_cycles != 6) begin n_fail++; $display("FAIL plain_cycles got %0d want 6", frame_cycles); end
    n_checks++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL plain_frame_cnt got %0d want %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_payload_escape();
    int d;
    logic [7:0] b;
    logic [7:0] c;
    for (int k = 0; k < 2; k++) begin
      b = (k == 0) ? 8'h7E : 8'h7D;
      c = (k == 0) ? 8'h81 : 8'h82;
      tx_q = '{b};
      run_frame();
      exp_q = '{8'h7E, 8'h7D, b ^ 8'h20, c, 8'h7E};
      exp_cnt++;
      d = first_diff();
      n_checks++; if (d != -1) begin n_fail++; $display("FAIL esc_%h_bytes idx %0d got %h want %h", b, d, cap_q[d], exp_q[d]); end
      n_checks++; if (rdy_q.size() != 1 || rdy_q[0] !== (b ^ 8'h20)) begin
        n_fail++; $display("FAIL esc_%h_ready pulses %0d wdata %h want 1 pulse on %h", b, rdy_q.size(), rdy_q[0], b ^ 8'h20);
      end
      n_checks++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL esc_%h_frame_cnt got %0d want %0d", b, frame_cnt, exp_cnt); end
    end
  endtask

  task automatic test_checksum_escape();
    int d;
    tx_q = '{8'h81};
    run_frame();
    exp_q = '{8'h7E, 8'h81, 8'h7D, 8'h5E, 8'h7E};
    exp_cnt++;
    d = first_diff();
    n_checks++; if (d != -1) begin n_fail++; $display("FAIL chk_esc_bytes idx %0d got %h want %h", d, cap_q[d], exp_q[d]); end
    n_checks++; if (frame_cycles != 6) begin n_fail++; $display("FAIL chk_esc_cycles got %0d want 6", frame_cycles); end
  endtask

  task automatic test_backpressure();
    int d;
    tx_q = '{8'h01, 8'h02, 8'h03};
    full_sched = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    run_frame();
    exp_q = '{8'h7E, 8'h01, 8'h02, 8'h03, 8'hF9, 8'h7E};
    exp_cnt++;
    d = first_diff();
    n_checks++; if (d != -1) begin n_fail++; $display("FAIL bp_data_bytes idx %0d got %h want %h", d, cap_q[d], exp_q[d]); end
    n_checks++; if (gate_viol != 0 || gate_seen != 3) begin n_fail++; $display("FAIL bp_data_gate violations %0d full cycles %0d want 0 and 3", gate_viol, gate_seen); end
    n_checks++; if (frame_cycles != 10) begin n_fail++; $display("FAIL bp_data_cycles got %0d want 10", frame_cycles); end
    n_checks++; if (!acc_ok()) begin n_fail++; $display("FAIL bp_data_accepted got %0d bytes want %0d", acc_q.size(), tx_q.size()); end

    tx_q = '{8'h81};
    full_sched = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    run_frame();
    exp_q = '{8'h7E, 8'h81, 8'h7D, 8'h5E, 8'h7E};
    exp_cnt++;
    d = first_diff();
    n_checks++; if (d != -1) begin n_fail++; $display("FAIL bp_chkx_bytes idx %0d got %h want %h", d, cap_q[d], exp_q[d]); end
    n_checks++; if (gate_viol != 0 || gate_seen != 3) begin n_fail++; $display("FAIL bp_chkx_gate violations %0d full cycles %0d want 0 and 3", gate_viol, gate_seen); end
    n_checks++; if (frame_cycles != 9) begin n_fail++; $display("FAIL bp_chkx_cycles got %0d want 9", frame_cycles); end
    n_checks++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL bp_frame_cnt got %0d want %0d", frame_cnt, exp_cnt); end
    full_sched.delete();
  endtask

  task automatic test_reset_midframe();
    int d;
    tx_q = '{8'h01, 8'h02, 8'h03};
    abort_after = 2;
    run_frame();
    abort_after = 0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || bus.o_wren !== 1'b0 || frame_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL midrst_async busy %b wren %b cnt %0d want 0 0 0", busy, bus.o_wren, frame_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cnt = 16'h0000;
    tx_q = '{8'h05};
    run_frame();
    exp_q = '{8'h7E, 8'h05, 8'hFA, 8'h7E};
    exp_cnt++;
    d = first_diff();
    n_checks++; if (d != -1) begin n_fail++; $display("FAIL midrst_bytes idx %0d got %h want %h", d, cap_q[d], exp_q[d]); end
    n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL midrst_frame_cnt got %0d want 1", frame_cnt); end
  endtask

  task automatic test_random();
    int d;
    int len;
    int sel;
    rand_full = 1'b1;
    rand_gap  = 1'b1;
    for (int f = 0; f < 30; f++) begin
      tx_q.delete();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        sel = $urandom_range(0, 5);
        tx_q.push_back(sel == 0 ? FLAG : sel == 1 ? ESC : sel == 2 ? 8'h82 : 8'($urandom));
      end
      run_frame();
      build_exp();
      exp_cnt++;
      d = first_diff();
      n_checks++; if (d != -1) begin n_fail++; $display("FAIL rand%0d_bytes idx %0d got %h want %h", f, d, cap_q[d], exp_q[d]); end
      n_checks++; if (!acc_ok() || gate_viol != 0) begin n_fail++; $display("FAIL rand%0d_accept accepted %0d want %0d gate violations %0d", f, acc_q.size(), tx_q.size(), gate_viol); end
      n_checks++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL rand%0d_frame_cnt got %0d want %0d", f, frame_cnt, exp_cnt); end
    end
    rand_full = 1'b0;
    rand_gap  = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rand_full = 1'b0; rand_gap = 1'b0; abort_after = 0;
    exp_cnt = 16'h0000;
    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_data = 8'h00; bus.i_last = 1'b0; bus.i_full = 1'b0;
    test_reset();
    test_plain();
    test_payload_escape();
    test_checksum_escape();
    test_backpressure();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_framer.md
# fifo_wr_framer

Write-side framing stage that feeds the async FIFO write port in the `i_wrclk` domain. It accepts a byte stream with valid/ready/last from the producer and emits HDLC-style frames into the FIFO: start flag, byte-stuffed payload, a stuffed checksum byte, and an end flag. The FIFO's `o_full` provides backpressure. A write is issued only when the FIFO is not full, so no byte is ever dropped by the FIFO's internal full gating.

## Interface
- `FLAG`, default 8'h7E: frame delimiter byte.
- `ESC`, default 8'h7D: escape byte.
- `XMASK`, default 8'h20: XOR mask applied to an escaped byte.
- `i_wrclk`  input  1  write-domain clock.
- `i_wrst_n`  input  1  reset, asynchronous, active-low.
- `i_valid`  input  1  producer byte valid.
- `i_data`  input  8  producer payload byte.
- `i_last`  input  1  marks the final payload byte of a frame; qualified by `i_valid`.
- `o_ready`  output  1  payload byte accepted this cycle (combinational).
- `i_full`  input  1  FIFO full flag, driven by the FIFO `o_full`.
- `o_wren`  output  1  FIFO write enable (combinational); never high while `i_full`=1.
- `o_wdata`  output  8  FIFO write data (combinational).
- `o_busy`  output  1  high whenever state is not IDLE.
- `o_frame_cnt`  output  16  count of completed frames; wraps from 16'hFFFF to 0.

## Operation
- **States:** IDLE, SOF, DATA, DATA_X, CHK, CHK_X, EOF.
- **Checksum:** `sum` is an 8-bit register holding the sum of raw payload bytes, mod 256. The checksum byte is `~sum`.
- **Special byte:** a byte is special if it equals `FLAG` or `ESC`. A special byte is sent as `ESC` followed by (byte ^ `XMASK`).
- **Write rule:** "write" means `o_wren`=1. `o_wren` = (state ∈ {SOF, DATA with `i_valid`, DATA_X, CHK, CHK_X, EOF}) && !`i_full`. A state advances only on a write.
- **IDLE:**
  - `o_wren`=0, `o_ready`=0.
  - If `i_valid`=1, go to SOF. The byte is not consumed. `sum` clears to 0.
- **SOF:** `o_wdata`=`FLAG`; go to DATA.
- **DATA** (waits while `i_valid`=0):
  - Normal byte: `o_wdata`=`i_data`, `o_ready`=`o_wren`.
  - Special byte: `o_wdata`=`ESC`, `o_ready`=0, go to DATA_X.
- **DATA_X:** `o_wdata`=`i_data`^`XMASK`, `o_ready`=`o_wren`.
- **On acceptance** (`o_ready`=1):
  - `sum` <= `sum` + `i_data`.
  - Next state is CHK if `i_last`=1, else DATA.
- **CHK:**
  - If `~sum` is special: `o_wdata`=`ESC`, go to CHK_X.
  - Otherwise: `o_wdata`=`~sum`, go to EOF.
- **CHK_X:** `o_wdata`=`~sum`^`XMASK`; go to EOF.
- **EOF:**
  - `o_wdata`=`FLAG`; go to IDLE.
  - `o_frame_cnt` increments on this write.
- **`o_wdata` when `o_wren`=0:** don't-care, but stable. Drive 8'h00 in IDLE.
- **Producer rules:**
  - While `i_valid`=1 and `o_ready`=0, `i_data` and `i_last` hold stable. In DATA_X the stuffed byte is recomputed from the held input.
  - Frames carry at least one payload byte.
  - `i_valid` dropping mid-frame stalls DATA with no writes. This is legal.
- **Backpressure:** while `i_full`=1, `o_wren`=0 and `o_ready`=0. State, `sum`, and the pending byte are unchanged. No byte is lost or duplicated.
- **Reset (async assert, any state):**
  - State=IDLE, `sum`=0, `o_frame_cnt`=0.
  - `o_wren`=0, `o_ready`=0, `o_busy`=0, `o_wdata`=0.
  - A frame cut off by reset is left unterminated in the FIFO. The consumer resynchronises on the next `FLAG`.

## Timing
- First write (SOF) occurs on the cycle after IDLE samples `i_valid`=1.
- With no backpressure, a frame of N payload bytes, E of them special, with C=1 if the checksum is special (else 0), takes 1 + (N+E+C+3) cycles. The following cycle is IDLE.
- Throughput is one FIFO write per cycle inside a frame.
- There is at least 1 idle cycle between frames.
- `o_ready`, `o_wren`, and `o_wdata` are combinational from state, `i_valid`, `i_data`, `sum`, and `i_full`. They carry no register latency.

## Test plan
- **Reset:** assert `i_wrst_n`=0 with random inputs. Require `o_wren`=0, `o_ready`=0, `o_busy`=0, `o_frame_cnt`=0.
- **Plain frame:** payload 01, 02 (`i_last` on 02), `i_full`=0. Require FIFO bytes 7E 01 02 FC 7E on consecutive cycles and `o_frame_cnt`=1.
- **Payload escape:**
  - Payload 7E: require 7E 7D 5E 81 7E.
  - Payload 7D: require 7E 7D 5D 82 7E.
  - In both cases `o_ready` is high only on the second byte of the escape pair.
- **Checksum escape:** payload 81. Require 7E 81 7D 5E 7E.
- **Backpressure:** hold `i_full`=1 for 3 cycles during DATA, and separately during CHK_X. Require `o_wren`=0 and `o_ready`=0 throughout, then the exact byte sequence resumes with no loss or duplication.
- **Reset mid-frame:** assert reset after 7E 01 of a frame, release, then send payload 05. Require 7E 05 FA 7E and `o_frame_cnt`=1.
